parking_gate_ctrl: RTL and testbench



---
 rtl/parking_pkg.sv | 25 ++
 rtl/parking_gate_fsm.sv | 141 ++++++++++++++
 rtl/parking_gate_ctrl.sv | 80 ++++++++
 tb/tb_parking_gate_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller.
// Contents: the gate state enum, the badge class constants, the default barrier
// timing values, and a helper that sizes the per-gate timer.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2
    } gate_state_t;

    localparam logic UNI    = 1'b1;
    localparam logic PUBLIC = 1'b0;

    localparam int DEF_OPEN_TIMEOUT = 16;
    localparam int DEF_CLOSE_CYCLES = 4;

    // The timer must be able to hold the larger of the two phase lengths.
    function automatic int timer_width(input int open_timeout, input int close_cycles);
        int max_v;
        max_v = (open_timeout > close_cycles) ? open_timeout : close_cycles;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier: IDLE -> OPEN -> CLOSING -> IDLE, with a badge class latched
// when the barrier is granted.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   request        - car waiting at the barrier (level)
//   is_uni         - badge class, sampled together with request
//   passed         - pass sensor (level)
//   grant_ok       - 1 allows a request in IDLE to open the barrier
//   barrier_open   - barrier drive
//   car_event      - one-cycle pulse when a car passes an open barrier
//   is_uni_event   - latched class, valid only with car_event
//   reject         - one-cycle pulse: request refused (grant_ok low)
//   timeout        - one-cycle pulse: barrier gave up waiting for the car
// All outputs are registered.
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic request,
    input  logic is_uni,
    input  logic passed,
    input  logic grant_ok,
    output logic barrier_open,
    output logic car_event,
    output logic is_uni_event,
    output logic reject,
    output logic timeout
);

    localparam int TW = timer_width(OPEN_TIMEOUT, CLOSE_CYCLES);
    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};

    gate_state_t   state_r;
    gate_state_t   state_nx_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nx_s;
    logic [TW-1:0] timer_inc_s;
    logic          cls_r;
    logic          cls_nx_s;
    logic          barrier_r;
    logic          event_r;
    logic          event_nx_s;
    logic          is_uni_event_r;
    logic          reject_r;
    logic          reject_nx_s;
    logic          timeout_r;
    logic          timeout_nx_s;

    // Saturating increment: the timer never wraps.
    assign timer_inc_s = (timer_r == TIMER_MAX) ? timer_r : (timer_r + TW'(1));

    // Next-state, timer, class latch and next output values.
    always_comb begin
        state_nx_s   = state_r;
        timer_nx_s   = timer_r;
        cls_nx_s     = cls_r;
        event_nx_s   = 1'b0;
        reject_nx_s  = 1'b0;
        timeout_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (request) begin
                    if (grant_ok) begin
                        state_nx_s = OPEN;
                        cls_nx_s   = is_uni;
                        timer_nx_s = TIMER_ZERO;
                    end else begin
                        // Refused requests re-evaluate every cycle they stay high.
                        reject_nx_s = 1'b1;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            OPEN: begin
                // Pass wins over timeout when both happen in the same cycle.
                if (passed) begin
                    event_nx_s = 1'b1;
                    state_nx_s = CLOSING;
                    timer_nx_s = TIMER_ZERO;
                end else if (timer_r == OPEN_LAST) begin
                    timeout_nx_s = 1'b1;
                    state_nx_s   = CLOSING;
                    timer_nx_s   = TIMER_ZERO;
                end else begin
                    timer_nx_s = timer_inc_s;
                end
            end
            CLOSING: begin
                if (timer_r == CLOSE_LAST) begin
                    state_nx_s = IDLE;
                    timer_nx_s = TIMER_ZERO;
                end else begin
                    timer_nx_s = timer_inc_s;
                end
            end
            default: begin
                state_nx_s = IDLE;
                timer_nx_s = TIMER_ZERO;
                cls_nx_s   = PUBLIC;
            end
        endcase
    end

    // State, timer, class latch and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            timer_r        <= TIMER_ZERO;
            cls_r          <= PUBLIC;
            barrier_r      <= 1'b0;
            event_r        <= 1'b0;
            is_uni_event_r <= PUBLIC;
            reject_r       <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            timer_r        <= timer_nx_s;
            cls_r          <= cls_nx_s;
            barrier_r      <= (state_nx_s == OPEN);
            event_r        <= event_nx_s;
            is_uni_event_r <= event_nx_s & cls_r;
            reject_r       <= reject_nx_s;
            timeout_r      <= timeout_nx_s;
        end
    end

    assign barrier_open = barrier_r;
    assign car_event    = event_r;
    assign is_uni_event = is_uni_event_r;
    assign reject       = reject_r;
    assign timeout      = timeout_r;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Gate-side controller feeding the parking occupancy counter's event interface.
// Runs independent entry and exit barriers; entry grants depend on the vacancy
// flag of the car's class, exit always grants.
// Ports:
//   clock, reset                           - clock, synchronous active-high reset
//   entry_request/entry_is_uni/entry_passed - entry request, class, pass sensor
//   exit_request/exit_is_uni/exit_passed    - exit request, class, pass sensor
//   uni_is_vacated_space, is_vacated_space  - vacancy flags from the counter
//   entry_barrier_open, exit_barrier_open   - barrier drives
//   car_entered/is_uni_car_entered          - entry event pulse and its class
//   car_exited/is_uni_car_exited            - exit event pulse and its class
//   entry_reject, entry_timeout, exit_timeout - one-cycle status pulses
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic entry_request,
    input  logic entry_is_uni,
    input  logic entry_passed,
    input  logic exit_request,
    input  logic exit_is_uni,
    input  logic exit_passed,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic entry_barrier_open,
    output logic exit_barrier_open,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_reject,
    output logic entry_timeout,
    output logic exit_timeout
);

    logic entry_grant_ok_s;
    logic exit_reject_unused_s;

    assign entry_grant_ok_s = (entry_is_uni == UNI) ? uni_is_vacated_space : is_vacated_space;

    parking_gate_fsm #(
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES)
    ) u_entry (
        .clock        (clock),
        .reset        (reset),
        .request      (entry_request),
        .is_uni       (entry_is_uni),
        .passed       (entry_passed),
        .grant_ok     (entry_grant_ok_s),
        .barrier_open (entry_barrier_open),
        .car_event    (car_entered),
        .is_uni_event (is_uni_car_entered),
        .reject       (entry_reject),
        .timeout      (entry_timeout)
    );

    // Exit never checks vacancy, so its reject output stays low.
    parking_gate_fsm #(
        .OPEN_TIMEOUT (OPEN_TIMEOUT),
        .CLOSE_CYCLES (CLOSE_CYCLES)
    ) u_exit (
        .clock        (clock),
        .reset        (reset),
        .request      (exit_request),
        .is_uni       (exit_is_uni),
        .passed       (exit_passed),
        .grant_ok     (1'b1),
        .barrier_open (exit_barrier_open),
        .car_event    (car_exited),
        .is_uni_event (is_uni_car_exited),
        .reject       (exit_reject_unused_s),
        .timeout      (exit_timeout)
    );

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with OPEN_TIMEOUT=8, CLOSE_CYCLES=3.
// Inputs change 1 time unit after a rising edge; outputs are checked there too,
// so each check sees the registers updated by the preceding edge.
module tb_parking_gate_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic entry_request = 1'b0;
    logic entry_is_uni = 1'b0;
    logic entry_passed = 1'b0;
    logic exit_request = 1'b0;
    logic exit_is_uni = 1'b0;
    logic exit_passed = 1'b0;
    logic uni_is_vacated_space = 1'b0;
    logic is_vacated_space = 1'b0;
    logic entry_barrier_open;
    logic exit_barrier_open;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic entry_reject;
    logic entry_timeout;
    logic exit_timeout;
    logic [8:0] outs_s;

    int n_vec = 0;
    int n_err = 0;

    parking_gate_ctrl #(
        .OPEN_TIMEOUT (8),
        .CLOSE_CYCLES (3)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .entry_request        (entry_request),
        .entry_is_uni         (entry_is_uni),
        .entry_passed         (entry_passed),
        .exit_request         (exit_request),
        .exit_is_uni          (exit_is_uni),
        .exit_passed          (exit_passed),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .entry_barrier_open   (entry_barrier_open),
        .exit_barrier_open    (exit_barrier_open),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_reject         (entry_reject),
        .entry_timeout        (entry_timeout),
        .exit_timeout         (exit_timeout)
    );

    assign outs_s = {entry_barrier_open, exit_barrier_open, car_entered, is_uni_car_entered,
                     car_exited, is_uni_car_exited, entry_reject, entry_timeout, exit_timeout};

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        entry_request = 1'b0;
        exit_request = 1'b0;
        entry_passed = 1'b0;
        exit_passed = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;

        // Reset state
        step();
        step();
        reset = 1'b0;
        check_eq("reset_outs", 32'(outs_s), 32'h0);

        // Uni entry: granted, open 3 cycles, pass, one event, 3 closing cycles
        entry_request = 1'b1; entry_is_uni = 1'b1;
        uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
        step();
        entry_request = 1'b0;
        check_eq("uni_open_c3", 32'(entry_barrier_open), 32'h1);
        step();
        check_eq("uni_open_c4", 32'(entry_barrier_open), 32'h1);
        step();
        check_eq("uni_open_c5", 32'(entry_barrier_open), 32'h1);
        check_eq("uni_no_evt_c5", 32'(car_entered), 32'h0);
        entry_passed = 1'b1;
        step();
        entry_passed = 1'b0;
        check_eq("uni_evt_c6", 32'(car_entered), 32'h1);
        check_eq("uni_cls_c6", 32'(is_uni_car_entered), 32'h1);
        check_eq("uni_bar_c6", 32'(entry_barrier_open), 32'h0);
        // request held through CLOSING is only taken once IDLE is reached
        entry_request = 1'b1;
        step();
        check_eq("uni_evt_c7", 32'(car_entered), 32'h0);
        check_eq("uni_cls_c7", 32'(is_uni_car_entered), 32'h0);
        check_eq("uni_bar_c7", 32'(entry_barrier_open), 32'h0);
        step();
        check_eq("uni_bar_c8", 32'(entry_barrier_open), 32'h0);
        step();
        check_eq("uni_bar_c9", 32'(entry_barrier_open), 32'h0);
        step();
        check_eq("uni_regrant_c10", 32'(entry_barrier_open), 32'h1);
        do_reset();

        // Public entry rejected for 3 cycles; uni vacancy must not be used
        entry_request = 1'b1; entry_is_uni = 1'b0;
        uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("rej_pulse%0d", i), 32'(entry_reject), 32'h1);
            check_eq($sformatf("rej_bar%0d", i), 32'(entry_barrier_open), 32'h0);
            check_eq($sformatf("rej_evt%0d", i), 32'(car_entered), 32'h0);
        end
        entry_request = 1'b0;
        step();
        check_eq("rej_end", 32'(entry_reject), 32'h0);
        // Uni entry with only public vacancy is rejected too
        entry_request = 1'b1; entry_is_uni = 1'b1;
        uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
        step();
        entry_request = 1'b0;
        check_eq("rej_uni", 32'(entry_reject), 32'h1);
        check_eq("rej_uni_bar", 32'(entry_barrier_open), 32'h0);
        do_reset();

        // Entry timeout: open 8 cycles, one timeout pulse, IDLE 3 cycles later
        entry_request = 1'b1; entry_is_uni = 1'b0; is_vacated_space = 1'b1;
        step();
        entry_request = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("to_open%0d", i), 32'(entry_barrier_open), 32'h1);
            check_eq($sformatf("to_early%0d", i), 32'(entry_timeout), 32'h0);
            step();
        end
        check_eq("to_pulse", 32'(entry_timeout), 32'h1);
        check_eq("to_bar", 32'(entry_barrier_open), 32'h0);
        check_eq("to_no_evt", 32'(car_entered), 32'h0);
        entry_request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("to_close%0d", i), 32'(entry_barrier_open), 32'h0);
            check_eq($sformatf("to_once%0d", i), 32'(entry_timeout), 32'h0);
        end
        step();
        check_eq("to_regrant", 32'(entry_barrier_open), 32'h1);
        do_reset();

        // Simultaneous entry (uni) and exit (public) events
        entry_request = 1'b1; entry_is_uni = 1'b1; uni_is_vacated_space = 1'b1;
        exit_request = 1'b1; exit_is_uni = 1'b0;
        step();
        entry_request = 1'b0; exit_request = 1'b0;
        check_eq("sim_bars", 32'({entry_barrier_open, exit_barrier_open}), 32'h3);
        entry_passed = 1'b1; exit_passed = 1'b1;
        step();
        entry_passed = 1'b0; exit_passed = 1'b0;
        check_eq("sim_events", 32'({car_entered, car_exited}), 32'h3);
        check_eq("sim_cls_in", 32'(is_uni_car_entered), 32'h1);
        check_eq("sim_cls_out", 32'(is_uni_car_exited), 32'h0);
        do_reset();

        // Exit ignores vacancy, keeps its uni class, and times out on its own
        uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;
        exit_request = 1'b1; exit_is_uni = 1'b1;
        step();
        exit_request = 1'b0;
        check_eq("exit_grant", 32'(exit_barrier_open), 32'h1);
        check_eq("exit_no_rej", 32'(entry_reject), 32'h0);
        exit_passed = 1'b1;
        step();
        exit_passed = 1'b0;
        check_eq("exit_evt", 32'({car_exited, is_uni_car_exited}), 32'h3);
        do_reset();
        exit_request = 1'b1;
        step();
        exit_request = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_eq("exit_to", 32'({exit_timeout, exit_barrier_open, car_exited}), 32'h4);
        do_reset();

        // Pass sensor held 6 cycles: exactly one event, none from IDLE
        entry_request = 1'b1; entry_is_uni = 1'b0; is_vacated_space = 1'b1;
        step();
        entry_request = 1'b0;
        entry_passed = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (car_entered) pulses++;
        end
        entry_passed = 1'b0;
        check_eq("held_pulses", 32'(pulses), 32'd1);
        check_eq("held_bar", 32'(entry_barrier_open), 32'h0);
        do_reset();

        // Reset while OPEN with pass in the same cycle: no event, all zero
        entry_request = 1'b1; entry_is_uni = 1'b1; uni_is_vacated_space = 1'b1;
        step();
        entry_request = 1'b0;
        check_eq("rst_pre_open", 32'(entry_barrier_open), 32'h1);
        entry_passed = 1'b1; reset = 1'b1;
        step();
        check_eq("rst_all_zero", 32'(outs_s), 32'h0);
        reset = 1'b0; entry_passed = 1'b0;
        step();
        check_eq("rst_after", 32'(outs_s), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
